// File: rtl/prbs8_checker.sv
// -----------------------------------------------------------------------------
// prbs8_checker
//
// Receive-side checker for the 8-bit LFSR pattern generator
// (feedback = s[1]^s[2]^s[3]^s[7], shifted in at the LSB).
//
// The checker works in three states:
//   SEARCH - load 8 received bits into the history register.
//   VERIFY - keep loading received bits and count consecutive correct
//            predictions. LOCK_CNT of them in a row declares lock.
//   LOCKED - the history free-runs on its own prediction. Each received bit
//            is compared with the prediction. UNLOCK_CNT consecutive misses
//            drop back to SEARCH.
//
// Ports:
//   i_clk      clock
//   i_rstn     asynchronous active-low reset
//   i_valid    i_bit is valid this cycle; everything is frozen while low
//   i_bit      received serial bit
//   i_clr      synchronous clear of both counters; takes effect on valid cycles
//   o_lock     high while LOCKED
//   o_err      one-cycle pulse per mismatched bit while LOCKED
//   o_err_cnt  saturating count of mismatches seen while LOCKED
//   o_bit_cnt  saturating count of bits checked while LOCKED
// -----------------------------------------------------------------------------
module prbs8_checker #(
    parameter int LOCK_CNT   = 16,
    parameter int UNLOCK_CNT = 4,
    parameter int ERR_W      = 16,
    parameter int CNT_W      = 32
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic             i_valid,
    input  logic             i_bit,
    input  logic             i_clr,
    output logic             o_lock,
    output logic             o_err,
    output logic [ERR_W-1:0] o_err_cnt,
    output logic [CNT_W-1:0] o_bit_cnt
);

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    // Run counters hold 0..N-1; the terminal event happens on the bit that
    // would take them to N.
    localparam logic [7:0]       LOCK_LAST   = 8'(LOCK_CNT - 1);
    localparam logic [7:0]       UNLOCK_LAST = 8'(UNLOCK_CNT - 1);
    localparam logic [ERR_W-1:0] ERR_ONE     = {{(ERR_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           r_state;
    logic [7:0]       r_hist;     // r_hist[0] is the most recent bit
    logic [2:0]       r_fill;     // wraps to 0 on the 8th bit of SEARCH
    logic [7:0]       r_match;
    logic [7:0]       r_miss;
    logic             r_lock;
    logic             r_err;
    logic [ERR_W-1:0] r_err_cnt;
    logic [CNT_W-1:0] r_bit_cnt;

    logic w_pred;
    logic w_hist_zero;
    logic w_err_inc;
    logic w_bit_inc;

    assign w_pred      = r_hist[1] ^ r_hist[2] ^ r_hist[3] ^ r_hist[7];
    // An all-zero history predicts 0 forever, so it must never count as a
    // match or a dead line would lock.
    assign w_hist_zero = (r_hist == 8'd0);
    assign w_bit_inc   = i_valid && (r_state == ST_LOCKED);
    assign w_err_inc   = w_bit_inc && (i_bit != w_pred);

    // NOTE: every register below is assigned with <= so all updates use the
    // pre-edge values, exactly like the flops they describe.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_state   <= ST_SEARCH;
            r_hist    <= 8'd0;
            r_fill    <= 3'd0;
            r_match   <= 8'd0;
            r_miss    <= 8'd0;
            r_lock    <= 1'b0;
            r_err     <= 1'b0;
            r_err_cnt <= '0;
            r_bit_cnt <= '0;
        end else begin
            r_err <= 1'b0;
            if (i_valid) begin
                case (r_state)
                    ST_SEARCH: begin
                        r_hist <= {r_hist[6:0], i_bit};
                        r_fill <= r_fill + 3'd1;
                        if (r_fill == 3'd7) begin
                            r_state <= ST_VERIFY;
                            r_match <= 8'd0;
                        end
                    end
                    ST_VERIFY: begin
                        // Always load the received bit: the history resyncs
                        // itself to the incoming sequence.
                        r_hist <= {r_hist[6:0], i_bit};
                        if ((i_bit == w_pred) && !w_hist_zero) begin
                            if (r_match == LOCK_LAST) begin
                                r_state <= ST_LOCKED;
                                r_lock  <= 1'b1;
                                r_miss  <= 8'd0;
                            end else begin
                                r_match <= r_match + 8'd1;
                            end
                        end else begin
                            r_match <= 8'd0;
                        end
                    end
                    ST_LOCKED: begin
                        // Free-run on the prediction so a single line error
                        // is not fed back into the history.
                        r_hist <= {r_hist[6:0], w_pred};
                        if (i_bit != w_pred) begin
                            r_err <= 1'b1;
                            if (r_miss == UNLOCK_LAST) begin
                                r_state <= ST_SEARCH;
                                r_lock  <= 1'b0;
                                r_fill  <= 3'd0;
                            end else begin
                                r_miss <= r_miss + 8'd1;
                            end
                        end else begin
                            r_miss <= 8'd0;
                        end
                    end
                    default: begin
                        r_state <= ST_SEARCH;
                        r_lock  <= 1'b0;
                        r_fill  <= 3'd0;
                    end
                endcase

                // A clear coinciding with an event keeps that event (loads 1).
                if (i_clr) begin
                    r_err_cnt <= w_err_inc ? ERR_ONE : '0;
                    r_bit_cnt <= w_bit_inc ? CNT_ONE : '0;
                end else begin
                    if (w_err_inc && (r_err_cnt != '1)) begin
                        r_err_cnt <= r_err_cnt + ERR_ONE;
                    end
                    if (w_bit_inc && (r_bit_cnt != '1)) begin
                        r_bit_cnt <= r_bit_cnt + CNT_ONE;
                    end
                end
            end
        end
    end

    assign o_lock    = r_lock;
    assign o_err     = r_err;
    assign o_err_cnt = r_err_cnt;
    assign o_bit_cnt = r_bit_cnt;

endmodule

// File: tb/tb_prbs8_checker.sv
// -----------------------------------------------------------------------------
// tb_prbs8_checker
//
// Drives a PRBS stream from a software copy of the 8-bit generator into two
// checkers (default parameters and a 4-bit error counter) and compares them
// against a behavioural model kept here. Inputs change on the falling edge;
// outputs are read 1 ns after the rising edge.
// -----------------------------------------------------------------------------
module tb_prbs8_checker;

    logic        clk;
    logic        rstn;
    logic        valid;
    logic        bit_in;
    logic        clr;
    logic        lock;
    logic        err;
    logic [15:0] err_cnt;
    logic [31:0] bit_cnt;
    logic        s_lock;
    logic        s_err;
    logic [3:0]  s_err_cnt;
    logic [31:0] s_bit_cnt;

    int n_checks = 0;
    int n_errors = 0;

    prbs8_checker dut (
        .i_clk     (clk),
        .i_rstn    (rstn),
        .i_valid   (valid),
        .i_bit     (bit_in),
        .i_clr     (clr),
        .o_lock    (lock),
        .o_err     (err),
        .o_err_cnt (err_cnt),
        .o_bit_cnt (bit_cnt)
    );

    prbs8_checker #(.ERR_W(4)) dut_sat (
        .i_clk     (clk),
        .i_rstn    (rstn),
        .i_valid   (valid),
        .i_bit     (bit_in),
        .i_clr     (clr),
        .o_lock    (s_lock),
        .o_err     (s_err),
        .o_err_cnt (s_err_cnt),
        .o_bit_cnt (s_bit_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus source: the 8-bit generator ----------------
    logic [7:0] g_state;

    function automatic logic gen_next();
        logic fb;
        fb      = g_state[1] ^ g_state[2] ^ g_state[3] ^ g_state[7];
        g_state = {g_state[6:0], fb};
        return fb;
    endfunction

    // ---------------- behavioural reference model ----------------
    typedef enum {M_SEARCH, M_VERIFY, M_LOCKED} mode_t;

    bit          m_hist[$];   // last 8 bits, oldest first
    mode_t       m_mode;
    int          m_seen;
    int          m_run;
    int          m_miss;
    logic        m_lock;
    logic        m_err;
    logic [15:0] m_err_cnt;
    logic [3:0]  m_err4;
    logic [31:0] m_bit_cnt;

    task automatic model_reset();
        m_hist.delete();
        for (int k = 0; k < 8; k++) m_hist.push_back(1'b0);
        m_mode    = M_SEARCH;
        m_seen    = 0;
        m_run     = 0;
        m_miss    = 0;
        m_lock    = 1'b0;
        m_err     = 1'b0;
        m_err_cnt = '0;
        m_err4    = '0;
        m_bit_cnt = '0;
    endtask

    task automatic model_push(input bit x);
        m_hist.push_back(x);
        void'(m_hist.pop_front());
    endtask

    task automatic model_step(input logic b, input logic v, input logic c);
        bit   p;
        bit   zero;
        logic inc_err;
        logic inc_bit;
        m_err   = 1'b0;
        inc_err = 1'b0;
        inc_bit = 1'b0;
        if (!v) return;
        // Newest bit is m_hist[7]; taps 1,2,3,7 steps back from it.
        p    = m_hist[6] ^ m_hist[5] ^ m_hist[4] ^ m_hist[0];
        zero = 1'b1;
        foreach (m_hist[k]) if (m_hist[k]) zero = 1'b0;
        case (m_mode)
            M_SEARCH: begin
                model_push(b);
                m_seen++;
                if (m_seen == 8) begin
                    m_mode = M_VERIFY;
                    m_run  = 0;
                end
            end
            M_VERIFY: begin
                model_push(b);
                m_run = ((b == p) && !zero) ? m_run + 1 : 0;
                if (m_run == 16) begin
                    m_mode = M_LOCKED;
                    m_miss = 0;
                end
            end
            default: begin
                model_push(p);
                inc_bit = 1'b1;
                if (b != p) begin
                    m_err   = 1'b1;
                    inc_err = 1'b1;
                    m_miss++;
                    if (m_miss == 4) begin
                        m_mode = M_SEARCH;
                        m_seen = 0;
                    end
                end else begin
                    m_miss = 0;
                end
            end
        endcase
        if (c) begin
            m_err_cnt = inc_err ? 16'd1 : 16'd0;
            m_err4    = inc_err ? 4'd1 : 4'd0;
            m_bit_cnt = inc_bit ? 32'd1 : 32'd0;
        end else begin
            if (inc_err && m_err_cnt != 16'hFFFF) m_err_cnt = m_err_cnt + 16'd1;
            if (inc_err && m_err4 != 4'hF)        m_err4    = m_err4 + 4'd1;
            if (inc_bit && m_bit_cnt != 32'hFFFF_FFFF) m_bit_cnt = m_bit_cnt + 32'd1;
        end
        m_lock = (m_mode == M_LOCKED);
    endtask

    // One input cycle: drive on the falling edge, read 1 ns after the rising
    // edge, then leave i_valid low so idle clocks change nothing.
    task automatic send(input logic b, input logic v, input logic c);
        @(negedge clk);
        valid  = v;
        bit_in = b;
        clr    = c;
        model_step(b, v, c);
        @(posedge clk);
        #1;
        valid = 1'b0;
        clr   = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        model_reset();
    endtask

    // Feed 24 clean valid bits and check that lock rises on exactly the 24th.
    task automatic acquire(input string tag);
        for (int i = 1; i <= 24; i++) begin
            send(gen_next(), 1'b1, 1'b0);
            if (i == 23) begin
                n_checks++;
                if (lock !== 1'b0) begin
                    n_errors++;
                    $display("FAIL %s_early: o_lock=%b after 23 bits, want 0", tag, lock);
                end
            end
        end
        n_checks++;
        if (lock !== 1'b1 || s_lock !== 1'b1) begin
            n_errors++;
            $display("FAIL %s_lock: o_lock=%b/%b after 24 bits, want 1", tag, lock, s_lock);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rstn = 1'b0; valid = 1'b0; bit_in = 1'b0; clr = 1'b0;
        model_reset();
        #12;
        n_checks++;
        if ({lock, err, err_cnt, bit_cnt, s_err_cnt} !== '0) begin
            n_errors++;
            $display("FAIL reset_values: lock=%b err=%b err_cnt=%0d bit_cnt=%0d, want all 0",
                     lock, err, err_cnt, bit_cnt);
        end
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic test_acquire();
        logic any_err;
        g_state = 8'd1;
        acquire("acquire");
        any_err = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            send(gen_next(), 1'b1, 1'b0);
            if (err !== 1'b0 || lock !== 1'b1) any_err = 1'b1;
        end
        n_checks++;
        if (err_cnt !== 16'd0 || bit_cnt !== 32'd1000 || any_err) begin
            n_errors++;
            $display("FAIL clean_1000: err_cnt=%0d bit_cnt=%0d glitch=%b, want 0/1000/0",
                     err_cnt, bit_cnt, any_err);
        end
    endtask

    task automatic test_single_flip();
        logic any_err;
        send(~gen_next(), 1'b1, 1'b0);
        n_checks++;
        if (err !== 1'b1 || err_cnt !== 16'd1 || lock !== 1'b1) begin
            n_errors++;
            $display("FAIL single_flip: err=%b err_cnt=%0d lock=%b, want 1/1/1", err, err_cnt, lock);
        end
        any_err = 1'b0;
        for (int i = 0; i < 100; i++) begin
            send(gen_next(), 1'b1, 1'b0);
            if (err !== 1'b0 || lock !== 1'b1) any_err = 1'b1;
        end
        n_checks++;
        if (err_cnt !== 16'd1 || any_err) begin
            n_errors++;
            $display("FAIL after_flip: err_cnt=%0d glitch=%b, want 1/0", err_cnt, any_err);
        end
    endtask

    task automatic test_burst();
        send(gen_next(), 1'b1, 1'b1);
        n_checks++;
        if (err_cnt !== 16'd0 || bit_cnt !== 32'd1) begin
            n_errors++;
            $display("FAIL clr_with_bit: err_cnt=%0d bit_cnt=%0d, want 0/1", err_cnt, bit_cnt);
        end
        for (int k = 1; k <= 4; k++) begin
            send(~gen_next(), 1'b1, 1'b0);
            n_checks++;
            if (err !== 1'b1 || lock !== (k < 4)) begin
                n_errors++;
                $display("FAIL burst_flip%0d: err=%b lock=%b, want 1/%b", k, err, lock, k < 4);
            end
        end
        n_checks++;
        if (err_cnt !== 16'd4) begin
            n_errors++;
            $display("FAIL burst_count: err_cnt=%0d, want 4", err_cnt);
        end
        acquire("relock");
        n_checks++;
        if (err_cnt !== 16'd4) begin
            n_errors++;
            $display("FAIL relock_count: err_cnt=%0d, want 4", err_cnt);
        end
    endtask

    task automatic test_valid_toggle();
        logic [31:0] snap;
        do_reset();
        g_state = 8'd1;
        for (int i = 1; i <= 24; i++) begin
            send(gen_next(), 1'b1, 1'b0);
            if (i == 23) begin
                n_checks++;
                if (lock !== 1'b0) begin
                    n_errors++;
                    $display("FAIL toggle_early: o_lock=%b after 23 valid bits, want 0", lock);
                end
            end
            send(1'($urandom), 1'b0, 1'b0);
        end
        n_checks++;
        if (lock !== 1'b1) begin
            n_errors++;
            $display("FAIL toggle_lock: o_lock=%b after 48 cycles, want 1", lock);
        end
        send(gen_next(), 1'b1, 1'b0);
        snap = bit_cnt;
        send(~gen_next(), 1'b0, 1'b1);
        n_checks++;
        if (bit_cnt !== snap || err !== 1'b0 || err_cnt !== 16'd0 || bit_cnt !== 32'd1) begin
            n_errors++;
            $display("FAIL invalid_frozen: bit_cnt=%0d err=%b err_cnt=%0d, want 1/0/0",
                     bit_cnt, err, err_cnt);
        end
    endtask

    task automatic test_all_zero();
        logic ever;
        do_reset();
        ever = 1'b0;
        for (int i = 0; i < 200; i++) begin
            send(1'b0, 1'b1, 1'b0);
            if (lock !== 1'b0) ever = 1'b1;
        end
        n_checks++;
        if (ever) begin
            n_errors++;
            $display("FAIL all_zero: o_lock rose on an all-zero stream, want never");
        end
    endtask

    task automatic test_saturation();
        do_reset();
        acquire("sat_acquire");
        for (int k = 0; k < 20; k++) begin
            send(~gen_next(), 1'b1, 1'b0);
            for (int j = 0; j < 3; j++) send(gen_next(), 1'b1, 1'b0);
        end
        n_checks++;
        if (s_err_cnt !== 4'd15 || err_cnt !== 16'd20 || lock !== 1'b1) begin
            n_errors++;
            $display("FAIL saturate: s_err_cnt=%0d err_cnt=%0d lock=%b, want 15/20/1",
                     s_err_cnt, err_cnt, lock);
        end
        send(~gen_next(), 1'b1, 1'b1);
        n_checks++;
        if (s_err_cnt !== 4'd1 || err_cnt !== 16'd1) begin
            n_errors++;
            $display("FAIL clr_and_flip: s_err_cnt=%0d err_cnt=%0d, want 1/1", s_err_cnt, err_cnt);
        end
        send(gen_next(), 1'b1, 1'b1);
        n_checks++;
        if (s_err_cnt !== 4'd0 || err_cnt !== 16'd0) begin
            n_errors++;
            $display("FAIL clr_alone: s_err_cnt=%0d err_cnt=%0d, want 0/0", s_err_cnt, err_cnt);
        end
    endtask

    task automatic test_async_reset();
        send(~gen_next(), 1'b1, 1'b0);
        send(gen_next(), 1'b1, 1'b0);
        @(posedge clk);
        #3;
        rstn = 1'b0;
        #1;
        n_checks++;
        if ({lock, err, err_cnt, bit_cnt, s_err_cnt} !== '0) begin
            n_errors++;
            $display("FAIL async_reset: lock=%b err=%b err_cnt=%0d bit_cnt=%0d, want all 0",
                     lock, err, err_cnt, bit_cnt);
        end
        model_reset();
        @(negedge clk);
        rstn = 1'b1;
        acquire("async_relock");
    endtask

    task automatic test_random();
        logic v;
        logic b;
        logic c;
        for (int i = 0; i < 600; i++) begin
            v = ($urandom_range(0, 3) != 0);
            c = ($urandom_range(0, 63) == 0);
            b = v ? (gen_next() ^ ($urandom_range(0, 15) == 0)) : 1'($urandom);
            send(b, v, c);
            n_checks++;
            if ({lock, err, err_cnt, bit_cnt, s_err_cnt} !==
                {m_lock, m_err, m_err_cnt, m_bit_cnt, m_err4}) begin
                n_errors++;
                $display("FAIL random_%0d: got lock=%b err=%b ec=%0d bc=%0d sec=%0d want %b/%b/%0d/%0d/%0d",
                         i, lock, err, err_cnt, bit_cnt, s_err_cnt,
                         m_lock, m_err, m_err_cnt, m_bit_cnt, m_err4);
            end
        end
    endtask

    initial begin
        test_reset();
        test_acquire();
        test_single_flip();
        test_burst();
        test_valid_toggle();
        test_all_zero();
        test_saturation();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/prbs8_checker.md
Name: prbs8_checker

Overview:
- Receive-side counterpart of the team's 8-bit LFSR pattern generator (feedback = s[1]^s[2]^s[3]^s[7], shifted in at LSB).
- Consumes a serial bit stream, self-synchronises to the PRBS sequence and declares lock.
- Once locked, free-runs a local generator and counts bit errors.
- Sits at the far end of a random-clock / test-pattern link for BIST and link checking.

Parameters:
- LOCK_CNT, 16: consecutive correct predictions in VERIFY required to declare lock (1..255).
- UNLOCK_CNT, 4: consecutive mismatches in LOCKED that force loss of lock (1..255).
- ERR_W, 16: width of the saturating error counter.
- CNT_W, 32: width of the saturating checked-bit counter.

Ports:
- i_clk  input  1  clock.
- i_rstn  input  1  asynchronous active-low reset.
- i_valid  input  1  i_bit is valid this cycle; all state is frozen when low.
- i_bit  input  1  received serial bit, equal to the generator's newly shifted-in LSB.
- i_clr  input  1  synchronous clear of o_err_cnt and o_bit_cnt; lock state is unaffected.
- o_lock  output  1  high while in LOCKED.
- o_err  output  1  one-cycle pulse per mismatched bit while LOCKED.
- o_err_cnt  output  ERR_W  saturating count of mismatches seen while LOCKED.
- o_bit_cnt  output  CNT_W  saturating count of valid bits checked while LOCKED.

Behaviour:
- Clock and reset: one clock, i_clk. Reset i_rstn is asynchronous and active-low.
- Reset values:
  - history register s[7:0] = 0; s[0] holds the most recent bit.
  - state = SEARCH; fill and match counters = 0.
  - o_lock = 0, o_err = 0, o_err_cnt = 0, o_bit_cnt = 0.
- Prediction: p = s[1]^s[2]^s[3]^s[7], combinational from the current history.
- SEARCH:
  - Each valid bit: s <= {s[6:0], i_bit}; fill counter increments.
  - After the 8th valid bit, go to VERIFY with match count = 0.
- VERIFY:
  - Each valid bit: s <= {s[6:0], i_bit}. The history is self-synchronising (always loads the received bit).
  - If i_bit == p and s != 0: match count increments.
  - Otherwise: match count resets to 0.
  - When match count reaches LOCK_CNT: go to LOCKED.
  - All-zero history never counts as a match, so an all-zero stream never locks.
- LOCKED:
  - Each valid bit: s <= {s[6:0], p}. The generator is free-running, so each line error counts exactly once.
  - o_bit_cnt increments.
  - On mismatch (i_bit != p): o_err pulses for 1 cycle, o_err_cnt increments, and the miss-run counter increments.
  - On match: the miss-run counter resets to 0.
  - When the miss-run counter reaches UNLOCK_CNT: go to SEARCH and clear the fill counter. The error counter keeps its value.
- Latency:
  - All outputs are registered.
  - o_lock rises in the cycle after the valid bit that completes LOCK_CNT matches. With continuous i_valid, that is 8+LOCK_CNT valid bits after reset.
  - o_lock falls in the cycle after the UNLOCK_CNT-th consecutive miss.
  - o_err is asserted in the cycle after the offending bit.
- Counters:
  - Both counters saturate at all-ones; no wrap-around.
  - i_clr and an increment in the same cycle: the counter loads 1, so that event is kept.
  - i_clr alone: the counter loads 0.
- i_valid low: no state, history or counter change; o_err = 0.
- Reset mid-operation: immediate return to reset values regardless of state.

Test Plan:
- Continuous stream from the 8-bit generator (SEED=1), i_valid=1 -> o_lock rises exactly 24 cycles after the first valid bit. Over the next 1000 bits: o_err_cnt=0, o_bit_cnt=1000.
- Locked; flip one bit -> one o_err pulse; o_err_cnt=1; o_lock stays 1; no further errors on the following 100 bits.
- Locked; flip 4 consecutive bits -> o_err_cnt=4; o_lock drops after the 4th flip; relock 24 valid bits later with o_err_cnt still 4.
- i_valid toggling 1/0 on a clean stream -> lock after 24 valid bits (48 cycles); no counter movement on invalid cycles. All-zero i_bit stream -> o_lock never rises.
- ERR_W=4, 20 isolated flips while locked -> o_err_cnt saturates at 15. i_clr in the same cycle as a flip -> o_err_cnt=1. i_clr alone -> 0.
- i_rstn pulsed low asynchronously (between clock edges) while locked -> all outputs 0 immediately; a normal relock follows after 24 valid bits.
